// File: rtl/pio_param_writer.sv
// pio_param_writer: writes NUM_WORDS snapshotted words to strided Avalon-MM PIO slaves; PIO_PARAM_WRITER_READBACK_EN adds readback verification
module pio_param_writer #(
  parameter int          NUM_WORDS = 4,
  parameter int          DATA_W    = 27,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] STRIDE    = 32'd16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_WORDS*DATA_W-1:0]   param_data,
  output logic [31:0]                   avm_address,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  output logic                          avm_read,
  input  logic [31:0]                   avm_readdata,
  input  logic                          avm_waitrequest,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);
  localparam int IW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
`ifdef PIO_PARAM_WRITER_READBACK_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
`endif
  state_t                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [NUM_WORDS*DATA_W-1:0]   snap_q, snap_d;
  logic                          err_q, err_d;
  logic [DATA_W-1:0]             word;
  logic                          last;
  logic                          unused_rd;
  assign word      = snap_q[idx_q*DATA_W +: DATA_W];
  assign last      = idx_q == IW'(NUM_WORDS-1);
  assign unused_rd = ^avm_readdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        snap_d  = param_data;
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = WRITE;
      end
      WRITE: if (!avm_waitrequest) begin
`ifdef PIO_PARAM_WRITER_READBACK_EN
        state_d = READ;
`else
        state_d = last ? DONE : WRITE;
        idx_d   = last ? idx_q : idx_q + IW'(1);
`endif
      end
`ifdef PIO_PARAM_WRITER_READBACK_EN
      READ: if (!avm_waitrequest) begin
        err_d   = err_q | (avm_readdata[DATA_W-1:0] != word);
        state_d = last ? DONE : WRITE;
        idx_d   = last ? idx_q : idx_q + IW'(1);
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign avm_write = state_q == WRITE;
`ifdef PIO_PARAM_WRITER_READBACK_EN
  assign avm_read = state_q == READ;
`else
  assign avm_read = 1'b0;
`endif
  // Bus fields read as zero whenever no strobe is active, including right after reset.
  assign avm_address   = (avm_write || avm_read) ? BASE_ADDR + 32'(idx_q) * STRIDE : '0;
  assign avm_writedata = avm_write ? 32'(word) : '0;
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign error         = err_q;
endmodule

// File: tb/tb_pio_param_writer.sv
// tb_pio_param_writer: scoreboard bench for pio_param_writer with a stalling/corrupting Avalon slave model
module tb_pio_param_writer;
  localparam int NW = 4;
  localparam int DW = 27;
`ifdef PIO_PARAM_WRITER_READBACK_EN
  localparam int LAT = 2*NW + 1;
  localparam bit RB  = 1'b1;
`else
  localparam int LAT = NW + 1;
  localparam bit RB  = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [NW*DW-1:0] param_data = '0;
  logic [31:0] avm_address, avm_writedata, avm_readdata = '0;
  logic avm_write, avm_read, avm_waitrequest = 1'b0, busy, done, error;

  pio_param_writer dut (
    .clk(clk), .reset(reset), .start(start), .param_data(param_data),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_read(avm_read), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  typedef struct {int c; logic e;} dn_t;
  wr_t wq[$];
  dn_t dq[$];
  int checks = 0, failures = 0, cyc = 0;
  logic [DW-1:0] words[NW];
  logic [31:0] stall_addr = '1, bad_addr = '1, last_wd = '0;
  int stall_n = 0, run_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: stalls the chosen address for stall_n cycles, corrupts readback of bad_addr to 0x5.
  always @(posedge clk) begin
    #1;
    if (!(avm_write && avm_address == stall_addr)) run_cnt = 0;
    avm_waitrequest = avm_write && avm_address == stall_addr && run_cnt < stall_n;
    if (avm_waitrequest) run_cnt++;
    avm_readdata = (avm_read && avm_address == bad_addr) ? 32'h5 : last_wd;
  end

  always @(negedge clk) begin
    if (!reset) chk("wr_rd_excl", {31'b0, avm_write & avm_read}, 32'h0);
    if (avm_write) begin
      if (wq.size() == 0) chk("unexpected_write", avm_address, 32'hFFFF_FFFF);
      else begin
        chk("wr_addr", avm_address, wq[0].a);
        chk("wr_data", avm_writedata, wq[0].d);
        if (!avm_waitrequest) begin
          last_wd = avm_writedata;
          void'(wq.pop_front());
        end
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 32'h1, 32'h0);
      else begin
        chk("done_cycle", 32'(cyc), 32'(dq[0].c));
        chk("done_error", {31'b0, error}, {31'b0, dq[0].e});
        void'(dq.pop_front());
      end
    end
  end

  task automatic scramble();
    for (int i = 0; i < NW; i++) param_data[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic run(input int stall_word, input int sn, input int bad_word, input bit repulse);
    int s;
    logic e;
    @(posedge clk); #2;
    for (int i = 0; i < NW; i++) param_data[i*DW +: DW] = words[i];
    stall_addr = stall_word < 0 ? 32'hFFFF_FFFF : 32'(stall_word * 16);
    stall_n    = sn;
    bad_addr   = bad_word < 0 ? 32'hFFFF_FFFF : 32'(bad_word * 16);
    e = RB && bad_word >= 0 && 32'(words[bad_word]) != 32'h5;
    for (int i = 0; i < NW; i++) wq.push_back('{32'(i * 16), 32'(words[i])});
    s = cyc;
    dq.push_back('{s + LAT + (stall_word < 0 ? 0 : sn), e});
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    scramble();
    if (repulse) begin
      @(posedge clk); #2;
      start = 1'b1;
      scramble();
      @(posedge clk); #2;
      start = 1'b0;
    end
    for (int k = 0; k < 50 && dq.size() != 0; k++) @(posedge clk);
    if (dq.size() != 0) begin
      chk("done_timeout", 32'(dq.size()), 32'h0);
      dq.delete();
    end
    @(posedge clk); #2;
    chk("writes_left", 32'(wq.size()), 32'h0);
    wq.delete();
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("err_sticky", {31'b0, error}, {31'b0, e});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    scramble();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_addr", avm_address, 32'h0);
    chk("rst_wdata", avm_writedata, 32'h0);
    chk("rst_ctl", {27'b0, avm_write, avm_read, busy, done, error}, 32'h0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #2;
    chk("rst_prio_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < NW; i++) words[i] = DW'(i + 1);
    run(-1, 0, -1, 1'b0);
    run(2, 3, -1, 1'b0);
    run(-1, 0, -1, 1'b1);
    run(2, 0, 2, 1'b0);
    run(-1, 0, -1, 1'b0);
    words[1] = 27'h7FF_FFFF;
    run(-1, 0, -1, 1'b0);
    // Reset lands on the cycle the second write is presented.
    for (int i = 0; i < NW; i++) words[i] = DW'($urandom);
    @(posedge clk); #2;
    for (int i = 0; i < NW; i++) param_data[i*DW +: DW] = words[i];
    stall_addr = '1;
    bad_addr   = '1;
    for (int i = 0; i < NW; i++) wq.push_back('{32'(i * 16), 32'(words[i])});
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int k = 0; k < 20 && !(avm_write && avm_address == 32'h10); k++) @(posedge clk) #2;
    chk("second_write_seen", avm_address, 32'h10);
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    chk("rst_mid_write", {31'b0, avm_write}, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    wq.delete();
    repeat (8) @(posedge clk);
    #2;
    chk("rst_no_resume", {30'b0, busy, done}, 32'h0);
    for (int r = 0; r < 20; r++) begin
      int bw;
      for (int i = 0; i < NW; i++) words[i] = DW'($urandom);
      bw = int'($urandom_range(0, NW)) - 1;
      if (bw >= 0 && $urandom_range(0, 1) == 1) words[bw] = DW'(5);
      run(int'($urandom_range(0, NW)) - 1, int'($urandom_range(0, 3)), bw, 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
